// File: rtl/matvec_loop_ctrl.sv
// ---------------------------------------------------------------------------
// matvec_loop_ctrl
//   Sequencer for a row-major matrix-vector datapath. It walks (row, col)
//   with row as the outer loop, issues one operand read per non-stalled
//   cycle, tracks those reads through a fixed-latency MAC pipeline, and
//   produces the accumulator clear/enable and per-row write-back strobes.
//   A one-cycle done pulse marks the end of the operation.
//
// Ports
//   i_clk, i_rst_n       clock (rising edge), async active-low reset
//   i_start              start command, sampled only while idle
//   i_abort              synchronous abort, returns to idle without done
//   i_num_rows/cols      matrix dimensions, latched at start
//   i_stall              memory not ready, no read issued this cycle
//   o_busy               high whenever not idle
//   o_rd_en              operand read strobe (combinational)
//   o_row_idx/o_col_idx  indices of the current read
//   o_acc_clr, o_acc_en  accumulator load / update at the MAC output
//   o_wr_en, o_wr_addr   result write strobe and row address
//   o_done               one-cycle completion pulse
// ---------------------------------------------------------------------------
module matvec_loop_ctrl #(
    parameter int SIZE_ADDR = 8,
    parameter int MAC_LAT   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [SIZE_ADDR-1:0] i_num_rows,
    input  logic [SIZE_ADDR-1:0] i_num_cols,
    input  logic                 i_stall,
    output logic                 o_busy,
    output logic                 o_rd_en,
    output logic [SIZE_ADDR-1:0] o_row_idx,
    output logic [SIZE_ADDR-1:0] o_col_idx,
    output logic                 o_acc_clr,
    output logic                 o_acc_en,
    output logic                 o_wr_en,
    output logic [SIZE_ADDR-1:0] o_wr_addr,
    output logic                 o_done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Side information that travels with each issued read.
    typedef struct packed {
        logic                 first_col;
        logic                 last_col;
        logic [SIZE_ADDR-1:0] row;
    } pipe_meta_t;

    state_t               state;
    logic [SIZE_ADDR-1:0] rows_q, cols_q;
    logic [SIZE_ADDR-1:0] row_q, col_q;

    logic [MAC_LAT:1]     vld_pipe;
    pipe_meta_t           meta_pipe [MAC_LAT:1];

    logic issue, at_last_col, at_last_row, pipe_empty, flush;

    assign issue       = (state == RUN) && !i_stall;
    assign at_last_col = (col_q == cols_q - SIZE_ADDR'(1));
    assign at_last_row = (row_q == rows_q - SIZE_ADDR'(1));
    assign pipe_empty  = (vld_pipe == '0);
    // Abort only matters once something is in flight.
    assign flush       = i_abort && (state != IDLE);

    assign o_rd_en   = issue;
    assign o_row_idx = row_q;
    assign o_col_idx = col_q;
    assign o_acc_en  = vld_pipe[MAC_LAT];
    assign o_acc_clr = vld_pipe[MAC_LAT] & meta_pipe[MAC_LAT].first_col;

    // ------------------------------------------------------------------
    // Control FSM and index counters
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            rows_q <= '0;
            cols_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (flush) begin
                state  <= IDLE;
                o_busy <= 1'b0;
                row_q  <= '0;
                col_q  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            rows_q <= i_num_rows;
                            cols_q <= i_num_cols;
                            row_q  <= '0;
                            col_q  <= '0;
                            o_busy <= 1'b1;
                            // Empty matrix: nothing to issue, finish at once.
                            if (i_num_rows != '0 && i_num_cols != '0) begin
                                state <= RUN;
                            end else begin
                                state  <= DONE;
                                o_done <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (issue) begin
                            if (at_last_col) begin
                                col_q <= '0;
                                // Final element: park indices at 0 rather
                                // than stepping past rows-1.
                                if (at_last_row) begin
                                    row_q <= '0;
                                    state <= DRAIN;
                                end else begin
                                    row_q <= row_q + SIZE_ADDR'(1);
                                end
                            end else begin
                                col_q <= col_q + SIZE_ADDR'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        // Pipe empty means the last row's write strobe is
                        // on o_wr_en this very cycle.
                        if (pipe_empty) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // MAC pipeline tracker and write-back strobe
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe  <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            for (int k = 1; k <= MAC_LAT; k++) begin
                meta_pipe[k] <= '0;
            end
        end else if (flush) begin
            vld_pipe <= '0;
            o_wr_en  <= 1'b0;
        end else begin
            // Stalled cycles enter as bubbles; the pipe never stops.
            vld_pipe[1]            <= issue;
            meta_pipe[1].first_col <= (col_q == '0);
            meta_pipe[1].last_col  <= at_last_col;
            meta_pipe[1].row       <= row_q;
            for (int k = 2; k <= MAC_LAT; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                meta_pipe[k] <= meta_pipe[k-1];
            end
            o_wr_en <= vld_pipe[MAC_LAT] & meta_pipe[MAC_LAT].last_col;
            if (vld_pipe[MAC_LAT] && meta_pipe[MAC_LAT].last_col) begin
                o_wr_addr <= meta_pipe[MAC_LAT].row;
            end
        end
    end

endmodule

// File: tb/tb_matvec_loop_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matvec_loop_ctrl
//   Self-checking bench. For each case a cycle-indexed table of expected
//   outputs is built from the element sequence and the stall pattern
//   (element e -> (e/cols, e%cols); MAC output at issue+MAC_LAT; row write
//   at last-col issue+MAC_LAT+1; done two cycles after the last MAC output).
// ---------------------------------------------------------------------------
module tb_matvec_loop_ctrl;

    localparam int SA = 8;
    localparam int L  = 2;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_stall = 1'b0;
    logic [SA-1:0] i_num_rows = '0;
    logic [SA-1:0] i_num_cols = '0;
    logic          o_busy, o_rd_en, o_acc_clr, o_acc_en, o_wr_en, o_done;
    logic [SA-1:0] o_row_idx, o_col_idx, o_wr_addr;

    matvec_loop_ctrl #(.SIZE_ADDR(SA), .MAC_LAT(L)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_num_rows(i_num_rows), .i_num_cols(i_num_cols), .i_stall(i_stall),
        .o_busy(o_busy), .o_rd_en(o_rd_en), .o_row_idx(o_row_idx),
        .o_col_idx(o_col_idx), .o_acc_clr(o_acc_clr), .o_acc_en(o_acc_en),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected-output tables, indexed by cycle offset from the start cycle.
    bit stl[];
    bit e_rd[], e_acc[], e_clr[], e_wr[], e_busy[], e_done[];
    int e_row[], e_col[], e_wa[];

    task automatic check_cycle(input int k);
        chk($sformatf("rd_en@%0d", k), 32'(o_rd_en), 32'(e_rd[k]));
        if (e_rd[k]) begin
            chk($sformatf("row_idx@%0d", k), 32'(o_row_idx), e_row[k]);
            chk($sformatf("col_idx@%0d", k), 32'(o_col_idx), e_col[k]);
        end
        chk($sformatf("acc_en@%0d", k),  32'(o_acc_en),  32'(e_acc[k]));
        chk($sformatf("acc_clr@%0d", k), 32'(o_acc_clr), 32'(e_clr[k]));
        chk($sformatf("wr_en@%0d", k),   32'(o_wr_en),   32'(e_wr[k]));
        if (e_wr[k]) chk($sformatf("wr_addr@%0d", k), 32'(o_wr_addr), e_wa[k]);
        chk($sformatf("done@%0d", k), 32'(o_done), 32'(e_done[k]));
        chk($sformatf("busy@%0d", k), 32'(o_busy), 32'(e_busy[k]));
    endtask

    // stall_pct < 0 selects the fixed pattern: stall on RUN cycles 2 and 5.
    // do_abort aborts on the cycle of the 4th issue. restart_cyc >= 1
    // re-asserts i_start (with rows=7) on that cycle.
    task automatic run_case(input int rows, input int cols, input int stall_pct,
                            input bit do_abort, input int restart_cyc);
        int n, cap, t, e, last_t, done_t, ka, h, nst;
        n   = rows * cols;
        cap = 2 * n + L + 8;
        stl    = new[cap]; e_rd  = new[cap]; e_acc  = new[cap]; e_clr = new[cap];
        e_wr   = new[cap]; e_busy = new[cap]; e_done = new[cap];
        e_row  = new[cap]; e_col = new[cap]; e_wa   = new[cap];
        nst = 0;
        for (int k = 0; k < cap; k++) begin
            if (stall_pct < 0) stl[k] = (k == 2 || k == 5);
            else if (k >= 1 && nst < n && int'($urandom_range(99)) < stall_pct) begin
                stl[k] = 1'b1;
                nst++;
            end
        end
        // Reference: walk the element list, skipping stalled cycles.
        t = 1; e = 0; last_t = 0; ka = -1;
        while (e < n) begin
            if (stl[t]) t++;
            else begin
                e_rd[t] = 1'b1; e_row[t] = e / cols; e_col[t] = e % cols;
                e_acc[t+L] = 1'b1;
                e_clr[t+L] = (e % cols == 0);
                if (e % cols == cols - 1) begin
                    e_wr[t+L+1] = 1'b1;
                    e_wa[t+L+1] = e / cols;
                end
                if (e == 3 && do_abort) ka = t;
                last_t = t;
                e++; t++;
            end
        end
        done_t = (n == 0) ? 1 : last_t + L + 2;
        for (int k = 1; k <= done_t; k++) e_busy[k] = 1'b1;
        e_done[done_t] = 1'b1;
        h = done_t;
        if (ka >= 0) begin
            h = ka + 2;
            for (int k = ka + 1; k < cap; k++) begin
                e_acc[k] = 0; e_clr[k] = 0; e_wr[k] = 0;
                e_busy[k] = 0; e_done[k] = 0; e_rd[k] = 0;
            end
        end
        // Cycle 0: idle, start presented.
        @(posedge i_clk); #1;
        i_start = 1'b1; i_abort = 1'b0; i_stall = stl[0];
        i_num_rows = SA'(rows); i_num_cols = SA'(cols);
        @(negedge i_clk); check_cycle(0);
        for (int k = 1; k <= h; k++) begin
            @(posedge i_clk); #1;
            i_start    = (k == restart_cyc);
            i_num_rows = (k == restart_cyc) ? SA'(7) : SA'($urandom);
            i_num_cols = SA'($urandom);
            i_stall    = stl[k];
            i_abort    = (k == ka);
            @(negedge i_clk); check_cycle(k);
        end
        i_start = 1'b0; i_abort = 1'b0; i_stall = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        @(negedge i_clk);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_rd_en", 32'(o_rd_en), 0);
        chk("rst_acc_en", 32'(o_acc_en), 0);
        chk("rst_wr_en", 32'(o_wr_en), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_idx", 32'({o_row_idx, o_col_idx, o_wr_addr}), 0);
        i_rst_n = 1'b1;

        // Abort while idle has no effect
        @(posedge i_clk); #1 i_abort = 1'b1;
        @(negedge i_clk); chk("idle_abort_busy", 32'(o_busy), 0);
        i_abort = 1'b0;

        run_case(2, 3, 0, 1'b0, -1);     // basic walk
        run_case(2, 3, -1, 1'b0, -1);    // stalls on RUN cycles 2 and 5
        run_case(0, 5, 0, 1'b0, -1);     // empty matrix
        run_case(3, 1, 0, 1'b0, -1);     // single column
        run_case(3, 4, 0, 1'b0, 3);      // start ignored while busy
        run_case(3, 4, 25, 1'b1, 2);     // restart ignored, then abort
        for (int i = 0; i < 8; i++)
            run_case(int'($urandom_range(6)), int'($urandom_range(6)), 30, 1'b0, -1);

        // Reset mid-operation discards work
        @(posedge i_clk); #1;
        i_start = 1'b1; i_num_rows = SA'(4); i_num_cols = SA'(4);
        @(posedge i_clk); #1 i_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #1 i_rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(o_busy), 0);
        chk("midrst_rd_en", 32'(o_rd_en), 0);
        chk("midrst_acc_en", 32'(o_acc_en), 0);
        @(negedge i_clk) i_rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clk);
            chk($sformatf("postrst_done@%0d", k), 32'(o_done | o_wr_en | o_busy), 0);
        end

        run_case(2, 2, 20, 1'b0, -1);    // clean start after reset
        run_case(255, 255, 0, 1'b0, -1); // maximum dimensions

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/matvec_loop_ctrl.md
Name: matvec_loop_ctrl

Overview:
- Sequencer for a row-major matrix-vector datapath (y[r] = sum over c of A[r][c]*x[c]).
- On a start command, walks a two-level index space: row outer, column inner.
- Issues one memory-read/MAC operand pair per cycle and tracks a fixed-latency MAC pipeline.
- Generates accumulator clear/enable and result write-back strobes, then pulses done.
- Sits between the top-level command interface and the index/MAC/memory datapath.

Parameters:
- SIZE_ADDR, 8: width of row/column counts and indices; max dimension 2^SIZE_ADDR-1.
- MAC_LAT, 2 (must be ≥1): cycles from o_rd_en issue to operands being valid at the accumulator input.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  start command pulse; sampled only in IDLE.
- i_abort  in  1  synchronous abort; returns to IDLE, no done.
- i_num_rows  in  SIZE_ADDR  row count; latched at start.
- i_num_cols  in  SIZE_ADDR  column count; latched at start.
- i_stall  in  1  memory not ready; suppresses issue this cycle.
- o_busy  out  1  high in any state other than IDLE.
- o_rd_en  out  1  operand read strobe.
- o_row_idx  out  SIZE_ADDR  row index of the current read.
- o_col_idx  out  SIZE_ADDR  column index of the current read.
- o_acc_clr  out  1  accumulator load-instead-of-add; first column of a row.
- o_acc_en  out  1  accumulator update enable.
- o_wr_en  out  1  result write strobe, one per row.
- o_wr_addr  out  SIZE_ADDR  row address for o_wr_en.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; indices 0; pipeline valid bits cleared.
  - Reset mid-operation discards all work; no o_done.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - i_start with rows>0 and cols>0: latch dims, clear row/col to 0, go to RUN next cycle.
  - i_start with rows==0 or cols==0: go to DONE directly; no reads, no writes.
- RUN (issue):
  - Each cycle with i_stall=0: o_rd_en=1 and (o_row_idx, o_col_idx) present the current pair. o_rd_en is combinational from state and i_stall.
  - Index advance after a non-stalled issue:
    - col==cols-1: col←0, row←row+1.
    - otherwise: col←col+1.
  - The issue with row==rows-1 and col==cols-1 moves the FSM to DRAIN.
  - i_stall=1: o_rd_en=0; indices hold; pipeline keeps advancing, with a bubble inserted.
- Pipeline tracking:
  - Shift register of depth MAC_LAT carrying {valid, first_col, last_col, row}.
  - Stage-MAC_LAT output drives o_acc_en=valid and o_acc_clr=valid&first_col.
  - o_wr_en is registered one cycle after stage output valid&last_col, with o_wr_addr=that row.
  - Write for a row therefore occurs MAC_LAT+1 cycles after its last-column issue.
  - cols==1: first_col and last_col are both set on the same element.
- DRAIN:
  - Stay until pipeline empty and the final o_wr_en has been emitted, then go to DONE.
- DONE:
  - o_done=1 for exactly one cycle, o_busy=1, then IDLE.
  - A new i_start is accepted in the IDLE cycle that follows.
- i_start while o_busy=1: ignored; latched dims unchanged.
- i_abort (any non-IDLE state):
  - Next cycle IDLE; pipeline flushed.
  - o_acc_en/o_wr_en forced 0 from the next cycle; no o_done.
  - i_abort outranks i_start in the same cycle.
  - i_abort in IDLE: no effect.
- Widths:
  - Indices never exceed dims-1; no wrap.
  - Comparisons use the latched dims, so input changes after start have no effect.
- Throughput: rows*cols issue cycles plus stalls. Total start→done = 1 + rows*cols + stalls + MAC_LAT + 2 cycles.

Test Plan:
- rows=2, cols=3, MAC_LAT=2, no stall:
  - rd_en for 6 consecutive cycles with (0,0)(0,1)(0,2)(1,0)(1,1)(1,2).
  - acc_clr on elems 0 and 3, each 2 cycles after issue.
  - wr_en at addr 0 and addr 1, each 3 cycles after its last-col issue.
  - done pulse once.
- Same dims, i_stall high on the 2nd and 5th RUN cycles:
  - indices hold across each stall; exactly 6 rd_en pulses; bubbles in acc_en; done delayed by 2 cycles.
- rows=0, cols=5 → no rd_en/wr_en; o_done one cycle after start; o_busy high only that cycle.
- rows=3, cols=1:
  - every element has acc_clr=1.
  - 3 wr_en pulses at addr 0,1,2.
- i_start re-asserted mid-RUN with rows=7: ignored, original sequence completes unchanged. Then i_abort at the 4th issue: no further acc_en/wr_en, no done, o_busy=0 the next cycle.
- rows=cols=255: final issue is (254,254); 255 wr_en pulses; no index wrap.
